// File: rtl/kv_defines_pkg.sv
// Shared key-vault geometry constants used by key-vault read clients.
// Entry/offset widths are common to all clients; the dword count is per consumer.
package kv_defines_pkg;

    localparam int KV_ENTRY_ADDR_W   = 5;
    localparam int KV_OFFSET_W       = 4;
    localparam int KV_DATA_W         = 32;
    localparam int KV_NUM_DWORDS_ECC = 12;

endpackage

// File: rtl/ecc_kv_key_fetch.sv
// Key-vault read client feeding the ECC register write port: reads one key entry
// dword by dword and streams it out with backpressure, zeroizing on demand.
module ecc_kv_key_fetch #(
    parameter int KV_ENTRY_ADDR_W = kv_defines_pkg::KV_ENTRY_ADDR_W,
    parameter int KV_OFFSET_W     = kv_defines_pkg::KV_OFFSET_W,
    parameter int KV_NUM_DWORDS   = kv_defines_pkg::KV_NUM_DWORDS_ECC,
    parameter int DATA_W          = kv_defines_pkg::KV_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [KV_ENTRY_ADDR_W-1:0] start_entry,
    input  logic                       zeroize,
    output logic                       kv_rd_en,
    output logic [KV_ENTRY_ADDR_W-1:0] kv_rd_entry,
    output logic [KV_OFFSET_W-1:0]     kv_rd_offset,
    input  logic [DATA_W-1:0]          kv_rd_data,
    input  logic                       kv_rd_error,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [KV_OFFSET_W-1:0]     wr_idx,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [KV_OFFSET_W-1:0] LAST_IDX = KV_OFFSET_W'(KV_NUM_DWORDS - 1);

    state_t                     state;
    state_t                     state_next;
    logic [KV_ENTRY_ADDR_W-1:0] entry_q;
    logic [KV_OFFSET_W-1:0]     cnt;
    logic [DATA_W-1:0]          hold;
    logic                       err_q;

    // Zeroize overrides everything except reset and never yields a done pulse.
    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RD;
            RD:   state_next = WR;
            WR: begin
                if (err_q) begin
                    state_next = DONE;
                end else if (wr_ready) begin
                    state_next = (cnt == LAST_IDX) ? DONE : RD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The latched entry survives zeroize; it is only visible while reading.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entry_q <= '0;
            cnt     <= '0;
            hold    <= '0;
            err_q   <= 1'b0;
        end else if (zeroize) begin
            cnt     <= '0;
            hold    <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        entry_q <= start_entry;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                    end
                end
                RD: begin
                    hold  <= kv_rd_data;
                    err_q <= kv_rd_error;
                end
                WR: begin
                    if (err_q) begin
                        hold <= '0;
                    end else if (wr_ready && (cnt != LAST_IDX)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        kv_rd_en     = 1'b0;
        kv_rd_entry  = '0;
        kv_rd_offset = '0;
        wr_valid     = 1'b0;
        wr_idx       = '0;
        wr_data      = '0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            RD: begin
                kv_rd_en     = 1'b1;
                kv_rd_entry  = entry_q;
                kv_rd_offset = cnt;
                busy         = 1'b1;
            end
            WR: begin
                busy = 1'b1;
                if (!err_q) begin
                    wr_valid = 1'b1;
                    wr_idx   = cnt;
                    wr_data  = hold;
                end
            end
            DONE:    done = 1'b1;
            default: begin
            end
        endcase
    end

    assign error = err_q;

endmodule
